// File: rtl/console_tx_sched.sv
// console_tx_sched: two-channel console byte scheduler in front of UartTx.
// ch0 carries tohost console characters, ch1 carries loader/system status bytes.
// Each channel owns a QDEPTH-entry FIFO, and a round-robin FSM hands bytes to
// UartTx one at a time.
// Optional feature macro: CONSOLE_CRLF_EN. When it is defined, every 0x0A is
// expanded to 0x0D,0x0A on the wire.
module console_tx_sched #(
   parameter int QDEPTH = 16
) (
   input  logic       w_clk,
   input  logic       w_rst,
   input  logic [7:0] c0_data,
   input  logic       c0_we,
   output logic       c0_full,
   input  logic [7:0] c1_data,
   input  logic       c1_we,
   output logic       c1_full,
   output logic [7:0] uart_data,
   output logic       uart_we,
   input  logic       uart_ready,
   output logic [1:0] ovf,
   output logic       busy
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] L_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] L_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] L_DEPTH = CW'(QDEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_GUARD = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [7:0]    r_mem0 [QDEPTH];
   logic [7:0]    r_mem1 [QDEPTH];
   logic [CW-1:0] r_head0;
   logic [CW-1:0] r_cnt0;
   logic [CW-1:0] r_head1;
   logic [CW-1:0] r_cnt1;
   logic          r_last_grant;
   logic [1:0]    r_ovf;
   logic [7:0]    r_uart_data;
   logic          r_uart_we;
`ifdef CONSOLE_CRLF_EN
   logic          r_pend_lf;
   logic          w_set_pend;
`endif

   logic          w_full0;
   logic          w_full1;
   logic          w_empty0;
   logic          w_empty1;
   logic          w_push0;
   logic          w_push1;
   logic          w_pop0;
   logic          w_pop1;
   logic [CW-1:0] w_wsum0;
   logic [CW-1:0] w_wsum1;
   logic [7:0]    w_head0;
   logic [7:0]    w_head1;
   logic          w_grant;
   logic          w_gch;
   logic          w_do_pop;
   logic [7:0]    w_gbyte;
   logic [7:0]    w_send_byte;

   assign w_full0  = (r_cnt0 == L_DEPTH);
   assign w_full1  = (r_cnt1 == L_DEPTH);
   assign w_empty0 = (r_cnt0 == L_ZERO);
   assign w_empty1 = (r_cnt1 == L_ZERO);
   // A push into a full FIFO is dropped even if the same cycle pops.
   assign w_push0  = c0_we & ~w_full0;
   assign w_push1  = c1_we & ~w_full1;
   assign w_pop0   = w_grant & w_do_pop & ~w_gch;
   assign w_pop1   = w_grant & w_do_pop & w_gch;
   // Write slot is (head + count) mod QDEPTH; dropping the top bit does the mod.
   assign w_wsum0  = r_head0 + r_cnt0;
   assign w_wsum1  = r_head1 + r_cnt1;
   assign w_head0  = r_mem0[r_head0[AW-1:0]];
   assign w_head1  = r_mem1[r_head1[AW-1:0]];

   assign c0_full   = w_full0;
   assign c1_full   = w_full1;
   assign uart_data = r_uart_data;
   assign uart_we   = r_uart_we;
   assign ovf       = r_ovf;
   assign busy      = (r_state != ST_IDLE) | ~w_empty0 | ~w_empty1;

   // ch0 FIFO storage; entries need no reset because head/count define validity.
   always_ff @(posedge w_clk) begin
      if (w_push0) begin
         r_mem0[w_wsum0[AW-1:0]] <= c0_data;
      end
   end

   // ch1 FIFO storage.
   always_ff @(posedge w_clk) begin
      if (w_push1) begin
         r_mem1[w_wsum1[AW-1:0]] <= c1_data;
      end
   end

   // ch0 head and occupancy; a simultaneous push and pop leave the count unchanged.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_head0 <= L_ZERO;
         r_cnt0  <= L_ZERO;
      end else begin
         if (w_pop0) begin
            r_head0 <= r_head0 + L_ONE;
         end
         case ({w_push0, w_pop0})
            2'b10:   r_cnt0 <= r_cnt0 + L_ONE;
            2'b01:   r_cnt0 <= r_cnt0 - L_ONE;
            default: r_cnt0 <= r_cnt0;
         endcase
      end
   end

   // ch1 head and occupancy.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_head1 <= L_ZERO;
         r_cnt1  <= L_ZERO;
      end else begin
         if (w_pop1) begin
            r_head1 <= r_head1 + L_ONE;
         end
         case ({w_push1, w_pop1})
            2'b10:   r_cnt1 <= r_cnt1 + L_ONE;
            2'b01:   r_cnt1 <= r_cnt1 - L_ONE;
            default: r_cnt1 <= r_cnt1;
         endcase
      end
   end

   // Sticky overflow: remembers any push attempted while that FIFO was full.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_ovf <= 2'b00;
      end else begin
         r_ovf <= r_ovf | {c1_we & w_full1, c0_we & w_full0};
      end
   end

   // Next-state logic, grant arbitration and selection of the byte to send.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_gch       = r_last_grant;
      w_do_pop    = 1'b0;
      w_gbyte     = 8'h00;
      w_send_byte = 8'h00;
`ifdef CONSOLE_CRLF_EN
      w_set_pend  = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (uart_ready && (!w_empty0 || !w_empty1)) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_SEND;
               // The channel that did not win last time gets first claim.
               if (r_last_grant) begin
                  w_gch = w_empty0 ? 1'b1 : 1'b0;
               end else begin
                  w_gch = w_empty1 ? 1'b0 : 1'b1;
               end
`ifdef CONSOLE_CRLF_EN
               // A CR has gone out, so its LF must follow from the same channel.
               if (r_pend_lf) begin
                  w_gch = r_last_grant;
               end else begin
                  w_gch = w_gch;
               end
`endif
               w_gbyte = w_gch ? w_head1 : w_head0;
`ifdef CONSOLE_CRLF_EN
               if (r_pend_lf) begin
                  w_send_byte = 8'h0A;
                  w_do_pop    = 1'b1;
               end else if (w_gbyte == 8'h0A) begin
                  w_send_byte = 8'h0D;
                  w_do_pop    = 1'b0;
                  w_set_pend  = 1'b1;
               end else begin
                  w_send_byte = w_gbyte;
                  w_do_pop    = 1'b1;
               end
`else
               w_send_byte = w_gbyte;
               w_do_pop    = 1'b1;
`endif
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SEND:  w_state_nxt = ST_GUARD;
         // READY from UartTx falls a cycle late, so it is not trusted here.
         ST_GUARD: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (uart_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // State register, registered UART outputs and arbitration history.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_uart_data  <= 8'h00;
         r_uart_we    <= 1'b0;
`ifdef CONSOLE_CRLF_EN
         r_pend_lf    <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_uart_we <= w_grant;
         if (w_grant) begin
            r_uart_data  <= w_send_byte;
            r_last_grant <= w_gch;
`ifdef CONSOLE_CRLF_EN
            r_pend_lf    <= w_set_pend;
`endif
         end
      end
   end

endmodule
